// File: rtl/fp_add_round_norm_if.sv
// Handshake bundle between the adder datapath, the round/normalize stage and its consumer.
interface fp_add_round_norm_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+4:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic                    out_overflow;
  logic                    out_underflow;
  logic                    out_inexact;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_add_round_norm.sv
// Normalize + RNE round + pack of the raw binary32 adder result; 2-cycle latency, 1/cycle.
// Backpressure: a stalled output holds stable; stage 1 keeps accepting while stage 2 has room.
module fp_add_round_norm #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input logic               clk,
  input logic               rst_n,
  fp_add_round_norm_if.slave io
);
  localparam int MW  = FRAC_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(MW);
  localparam int RW  = 1 + EXP_W + FRAC_W;
  localparam int SGW = FRAC_W + 2;

  // mant holds hidden..sticky; exp is 0 for a subnormal result
  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-2:0] mant;
  } s1_t;

  typedef struct packed {
    logic [RW-1:0] result;
    logic          ovf;
    logic          unf;
    logic          inx;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic adv, in_rdy, in_xfer;

  function automatic logic [LZW-1:0] lzc_f(input logic [MW-2:0] v);
    lzc_f = LZW'(MW - 1);
    for (int i = 0; i < MW - 1; i++) begin
      if (v[i]) lzc_f = LZW'(MW - 2 - i);
    end
  endfunction

  // Stage 1: normalize
  logic [LZW-1:0] lzc;
  logic [EW-1:0]  lzc_w, exp_m1, sh;
  logic [MW-2:0]  shifted;
  s1_t            norm;

  always_comb begin
    lzc     = lzc_f(io.in_mant[MW-2:0]);
    lzc_w   = EW'(lzc);
    exp_m1  = EW'(io.in_exp) - EW'(1);
    // left shift stops at the subnormal boundary
    sh      = (lzc_w < exp_m1) ? lzc_w : exp_m1;
    shifted = io.in_mant[MW-2:0] << sh;

    norm      = '0;
    norm.sign = io.in_sign;
    if (io.in_mant == '0) begin
      norm.exp  = '0;
      norm.mant = '0;
    end else if (io.in_mant[MW-1]) begin
      norm.exp  = EW'(io.in_exp) + EW'(1);
      norm.mant = {io.in_mant[MW-1:2], io.in_mant[1] | io.in_mant[0]};
    end else begin
      norm.mant = shifted;
      norm.exp  = shifted[MW-2] ? (EW'(io.in_exp) - sh) : '0;
    end
  end

  // Stage 2: round to nearest even, detect overflow/underflow, pack
  logic            lsb, g, r, s, rnd;
  logic [SGW-1:0]  sig;
  logic [EW-1:0]   exp_r;
  logic            ovf, inx;
  s2_t             pack;

  always_comb begin
    lsb = s1_q.mant[3];
    g   = s1_q.mant[2];
    r   = s1_q.mant[1];
    s   = s1_q.mant[0];
    rnd = g & (r | s | lsb);
    sig = {1'b0, s1_q.mant[MW-2:3]} + SGW'(rnd);
    // carry out of the significand, or a subnormal rounding up into the hidden bit
    exp_r = s1_q.exp + EW'(sig[SGW-1]) + EW'(~s1_q.mant[MW-2] & sig[SGW-2]);
    ovf   = (exp_r >= EW'((1 << EXP_W) - 1));
    inx   = g | r | s | ovf;

    pack = '0;
    if (ovf) begin
      pack.result = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      pack.result = {s1_q.sign, exp_r[EXP_W-1:0], sig[FRAC_W-1:0]};
    end
    pack.ovf = ovf;
    pack.inx = inx;
    pack.unf = (exp_r == '0) & inx;
  end

  // Pipeline control
  always_comb begin
    adv     = io.out_ready | ~s2_valid_q;
    in_rdy  = ~s1_valid_q | adv;
    in_xfer = io.in_valid & in_rdy;

    s1_valid_d = in_rdy ? io.in_valid : s1_valid_q;
    s1_d       = in_xfer ? norm : s1_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_d       = (adv & s1_valid_q) ? pack : s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign io.in_ready      = in_rdy;
  assign io.out_valid     = s2_valid_q;
  assign io.out_result    = s2_q.result;
  assign io.out_overflow  = s2_q.ovf;
  assign io.out_underflow = s2_q.unf;
  assign io.out_inexact   = s2_q.inx;

  a_exp_range: assert property (@(posedge clk) disable iff (!rst_n)
    io.in_valid |-> (io.in_exp != '0) && (io.in_exp != '1));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (io.out_valid && !io.out_ready) |=> (io.out_valid && $stable(io.out_result)));
endmodule
